// File: rtl/seq_mag_comparator.sv
// Iterative magnitude comparator: compares WIDTH-bit operands DIGIT bits per cycle,
// MSD first, with early exit on the first differing digit and signed/unsigned modes.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [2:0]       flags_q, flags_d;   // {alb, aeb, agb}
  logic             done_q, done_d;
  logic [WIDTH-1:0] msb_flip;
  logic [DIGIT-1:0] a_dig, b_dig;

  assign a_dig = a_sh_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_sh_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    // Signed mode is folded into the operands at load time: flipping the sign bit
    // maps two's-complement order onto unsigned order, so the datapath stays unsigned.
    msb_flip = '0;
    msb_flip[WIDTH-1] = signed_mode;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a ^ msb_flip;
          b_sh_d  = b ^ msb_flip;
          cnt_d   = CW'(N - 1);
          flags_d = 3'b000;
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_dig != b_dig) begin
          flags_d = {a_dig < b_dig, 1'b0, a_dig > b_dig};
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          flags_d = 3'b010;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_sh_d = a_sh_q << DIGIT;
          b_sh_d = b_sh_q << DIGIT;
          cnt_d  = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      flags_q <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign alb  = flags_q[2];
  assign aeb  = flags_q[1];
  assign agb  = flags_q[0];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Randomized self-checking bench for seq_mag_comparator against a behavioural model.
module tb_seq_mag_comparator;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, sm_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic busy, done, alb, aeb, agb;

  logic start2 = 1'b0, sm2 = 1'b0;
  logic [W-1:0] a2 = '0, b2 = '0;
  logic busy2, done2, alb2, aeb2, agb2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .start(start_i), .signed_mode(sm_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .alb(alb), .aeb(aeb), .agb(agb));

  seq_mag_comparator #(.WIDTH(W), .DIGIT(W)) dut_w (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .alb(alb2), .aeb(aeb2), .agb(agb2));

  // Model: order from integer arithmetic, latency from the first differing digit.
  function automatic void ref_cmp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rsm, output int lat, output logic [2:0] fl);
    int ia, ib;
    lat = N;
    for (int i = 0; i < N; i++) begin
      if (((ra >> (W - D*(i+1))) & 16'hF) != ((rb >> (W - D*(i+1))) & 16'hF)) begin
        lat = i + 1;
        break;
      end
    end
    if (rsm) begin
      ia = int'($signed(ra));
      ib = int'($signed(rb));
    end else begin
      ia = int'(ra);
      ib = int'(rb);
    end
    fl = {ia < ib, ia == ib, ia > ib};
  endfunction

  // Drives one compare and measures it; comparisons are made by the callers.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsm,
                        input bit hold_start, output int lat, output logic [2:0] fl,
                        output bit hs_bad);
    @(negedge clk);
    a_i = ta; b_i = tb_; sm_i = tsm; start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start_i = 1'b0;
    hs_bad = 1'b0;
    lat = -1;
    fl = 3'bxxx;
    for (int c = 1; c <= N + 2; c++) begin
      if (busy !== 1'b1 || {alb, aeb, agb} !== 3'b000 || done !== 1'b0) hs_bad = 1'b1;
      a_i = W'($urandom); b_i = W'($urandom); sm_i = 1'($urandom);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = c;
        fl = {alb, aeb, agb};
        if (busy !== 1'b0) hs_bad = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, alb, aeb, agb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, alb, aeb, agb});
    end
    checks++;
    if ({busy2, done2, alb2, aeb2, agb2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs_wide: got %b expected 00000", {busy2, done2, alb2, aeb2, agb2});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5] = '{16'h1234, 16'hC000, 16'hC000, 16'h8000, 16'h8000};
    logic [W-1:0] vb[5] = '{16'h1234, 16'h3000, 16'h3000, 16'h7FFF, 16'h7FFF};
    logic vs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat, elat;
    logic [2:0] fl, efl;
    bit hs_bad;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b0, lat, fl, hs_bad);
      ref_cmp(va[i], vb[i], vs[i], elat, efl);
      checks++;
      if (lat !== elat || fl !== efl || hs_bad) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d flags=%b hs_bad=%0d expected lat=%0d flags=%b",
                 i, lat, fl, hs_bad, elat, efl);
      end
    end
    // Mid-word difference, then the result must persist while idle.
    run_op(16'h12F4, 16'h1204, 1'b0, 1'b0, lat, fl, hs_bad);
    checks++;
    if (lat !== 3 || fl !== 3'b001 || hs_bad) begin
      errors++;
      $display("FAIL mid_word: lat=%0d flags=%b hs_bad=%0d expected lat=3 flags=001", lat, fl, hs_bad);
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if ({alb, aeb, agb} !== 3'b001 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flags_hold: flags=%b done=%b busy=%b expected 001 0 0", {alb, aeb, agb}, done, busy);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [2:0] fl;
    @(negedge clk);
    a_i = 16'h1235; b_i = 16'h1234; sm_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    a_i = 16'hFFFF; b_i = 16'h0000; sm_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    fl = 3'bxxx;
    for (int c = 2; c <= N + 2; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = c; fl = {alb, aeb, agb}; break; end
    end
    checks++;
    if (lat !== 4 || fl !== 3'b001) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d flags=%b expected lat=4 flags=001", lat, fl);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int lat, elat;
    logic [2:0] fl, efl;
    bit hs_bad;
    @(negedge clk);
    a_i = 16'h1234; b_i = 16'h1234; sm_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, alb, aeb, agb} !== 5'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected 00000", {busy, done, alb, aeb, agb});
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: activity seen=%0d expected 0", seen);
    end
    run_op(16'hABCD, 16'hABCE, 1'b0, 1'b0, lat, fl, hs_bad);
    ref_cmp(16'hABCD, 16'hABCE, 1'b0, elat, efl);
    checks++;
    if (lat !== elat || fl !== efl || hs_bad) begin
      errors++;
      $display("FAIL after_reset: lat=%0d flags=%b hs_bad=%0d expected lat=%0d flags=%b",
               lat, fl, hs_bad, elat, efl);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2:0] fl;
    bit hs_bad;
    run_op(16'hC000, 16'h3000, 1'b0, 1'b1, lat, fl, hs_bad);
    checks++;
    if (lat !== 1 || fl !== 3'b001 || hs_bad) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d flags=%b hs_bad=%0d expected lat=1 flags=001", lat, fl, hs_bad);
    end
    a_i = 16'h1234; b_i = 16'h1234; sm_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {alb, aeb, agb} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b flags=%b expected 1 0 000", busy, done, {alb, aeb, agb});
    end
    lat = -1;
    fl = 3'bxxx;
    for (int c = 1; c <= N + 2; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = c; fl = {alb, aeb, agb}; break; end
    end
    checks++;
    if (lat !== 4 || fl !== 3'b010) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d flags=%b expected lat=4 flags=010", lat, fl);
    end
  endtask

  task automatic test_random();
    int lat, elat, kind, d;
    logic [2:0] fl, efl;
    logic [W-1:0] ra, rb;
    logic rsm;
    bit hs_bad;
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rsm = 1'($urandom);
      kind = $urandom_range(0, 3);
      d = $urandom_range(0, N - 1);
      if (kind == 0) rb = W'($urandom);
      else if (kind == 1) rb = ra;
      else rb = ra ^ (W'($urandom_range(1, 15)) << (W - D*(d+1)));
      run_op(ra, rb, rsm, 1'b0, lat, fl, hs_bad);
      ref_cmp(ra, rb, rsm, elat, efl);
      checks++;
      if (lat !== elat || fl !== efl || hs_bad) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h s=%b lat=%0d flags=%b hs_bad=%0d expected lat=%0d flags=%b",
                 i, ra, rb, rsm, lat, fl, hs_bad, elat, efl);
      end
    end
  endtask

  task automatic test_wide_digit();
    logic [W-1:0] wa[3] = '{16'h1234, 16'h1234, 16'h8000};
    logic [W-1:0] wb[3] = '{16'h1234, 16'h1235, 16'h7FFF};
    logic ws[3] = '{1'b0, 1'b0, 1'b1};
    int elat;
    logic [2:0] efl;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a2 = wa[i]; b2 = wb[i]; sm2 = ws[i]; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      checks++;
      if (busy2 !== 1'b1 || {alb2, aeb2, agb2} !== 3'b000) begin
        errors++;
        $display("FAIL wide_busy_%0d: busy=%b flags=%b expected 1 000", i, busy2, {alb2, aeb2, agb2});
      end
      @(posedge clk); #1;
      ref_cmp(wa[i], wb[i], ws[i], elat, efl);
      checks++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || {alb2, aeb2, agb2} !== efl) begin
        errors++;
        $display("FAIL wide_result_%0d: done=%b busy=%b flags=%b expected 1 0 %b",
                 i, done2, busy2, {alb2, aeb2, agb2}, efl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_wide_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
